window_multiplier: RTL and testbench



---
 rtl/window_pkg.sv | 29 ++
 rtl/window_multiplier_rom.sv | 28 ++
 rtl/window_multiplier.sv | 195 +++++++++++++++++++
 tb/tb_window_multiplier.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types, defaults and the Hann coefficient generator for the window stage.
package window_pkg;

  localparam int  DEFAULT_WIDTH      = 14;
  localparam int  DEFAULT_LENGTH     = 2048;
  localparam int  DEFAULT_COEF_WIDTH = 16;
  localparam int  CNT_W              = $clog2(DEFAULT_LENGTH);
  localparam real HANN_PI            = 3.14159265358979323846;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } win_state_t;

  // Periodic Hann coefficient in unsigned Q0.coef_width, clamped so w = 1.0 fits.
  function automatic logic [31:0] hann_coef(input int n, input int length, input int coef_width);
    real    scale;
    real    v;
    longint r;
    longint lim;
    scale = real'(longint'(1) << coef_width);
    v     = 0.5 * (1.0 - $cos(2.0 * HANN_PI * real'(n) / real'(length))) * scale;
    r     = longint'(v);
    lim   = (longint'(1) << coef_width) - 1;
    if (r > lim) r = lim;
    return r[31:0];
  endfunction

endpackage

// File: rtl/window_multiplier_rom.sv
// Synchronous coefficient ROM holding one Hann window, read latency of one clock.
module window_rom
  import window_pkg::*;
#(
  parameter int LENGTH     = DEFAULT_LENGTH,
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
  parameter int CNT_W      = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic [CNT_W-1:0]      addr,
  output logic [COEF_WIDTH-1:0] coef_q
);

  logic [COEF_WIDTH-1:0] rom_mem [LENGTH];

  // Table contents are fixed at elaboration from the coefficient formula.
  initial begin
    for (int i = 0; i < LENGTH; i++) begin
      rom_mem[i] = COEF_WIDTH'(hann_coef(i, LENGTH, COEF_WIDTH));
    end
  end

  // Registered read so the coefficient lines up with the first data stage.
  always_ff @(posedge clk) begin
    coef_q <= rom_mem[addr];
  end

endmodule

// File: rtl/window_multiplier.sv
// Hann-window stage: framing FSM, index counter, 3-stage multiply pipeline and error status.
module window_multiplier
  import window_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LENGTH     = DEFAULT_LENGTH,
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sink_valid,
  input  logic                    sink_sop,
  input  logic                    sink_eop,
  input  logic signed [WIDTH-1:0] sink_data,
  output logic                    source_valid,
  output logic                    source_sop,
  output logic                    source_eop,
  output logic signed [WIDTH-1:0] source_data,
  input  logic                    clear_error,
  output logic                    status_error,
  output logic [7:0]              err_count
);

  localparam int CNT_W  = $clog2(LENGTH);
  localparam int PROD_W = WIDTH + COEF_WIDTH + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [CNT_W-1:0]        LAST_IDX   = CNT_W'(LENGTH - 1);
  localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(longint'(1) <<< (COEF_WIDTH - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((longint'(1) <<< (WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN    = -SAT_MAX - SUM_W'(1);

  win_state_t state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] beat_idx;
  logic             accept;
  logic             beat_last;
  logic             err_event;

  logic                    s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
  logic signed [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [COEF_WIDTH-1:0]   s1_coef;

  logic                     s2_valid_q, s2_valid_d, s2_sop_q, s2_sop_d, s2_eop_q, s2_eop_d;
  logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d;

  logic signed [SUM_W-1:0] round_sum, shifted;
  logic                    source_valid_q, source_valid_d, source_sop_q, source_sop_d;
  logic                    source_eop_q, source_eop_d;
  logic signed [WIDTH-1:0] source_data_q, source_data_d;

  logic       status_error_q, status_error_d;
  logic [7:0] err_count_q, err_count_d;

  window_rom #(
    .LENGTH     (LENGTH),
    .COEF_WIDTH (COEF_WIDTH),
    .CNT_W      (CNT_W)
  ) u_rom (
    .clk    (clk),
    .addr   (beat_idx),
    .coef_q (s1_coef)
  );

  // Decide whether the sink beat is emitted, which window index it uses, and if it is a framing error.
  always_comb begin
    accept    = sink_valid && ((state_q == IN_PKT) || sink_sop);
    beat_idx  = sink_sop ? '0 : n_q;
    beat_last = (beat_idx == LAST_IDX);
    state_d   = state_q;
    n_d       = n_q;
    err_event = 1'b0;
    if (sink_valid) begin
      if (!accept) begin
        err_event = 1'b1;
      end else begin
        if ((state_q == IN_PKT) && sink_sop) begin
          err_event = 1'b1;
        end else if (sink_eop != beat_last) begin
          err_event = 1'b1;
        end
        if (beat_last) begin
          state_d = IDLE;
          n_d     = '0;
        end else begin
          state_d = IN_PKT;
          n_d     = beat_idx + CNT_W'(1);
        end
      end
    end
  end

  // Packet state and sample index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Stage inputs: capture beat, multiply, then round and saturate; flags stay 0 on idle slots.
  always_comb begin
    s1_valid_d = accept;
    s1_sop_d   = accept && sink_sop;
    s1_eop_d   = accept && beat_last;
    s1_data_d  = accept ? sink_data : '0;

    s2_valid_d = s1_valid_q;
    s2_sop_d   = s1_sop_q;
    s2_eop_d   = s1_eop_q;
    s2_prod_d  = PROD_W'(s1_data_q) * PROD_W'($signed({1'b0, s1_coef}));

    round_sum = SUM_W'(s2_prod_q) + ROUND_BIAS;
    shifted   = round_sum >>> COEF_WIDTH;
    if (shifted > SAT_MAX) begin
      source_data_d = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      source_data_d = SAT_MIN[WIDTH-1:0];
    end else begin
      source_data_d = shifted[WIDTH-1:0];
    end
    source_valid_d = s2_valid_q;
    source_sop_d   = s2_sop_q;
    source_eop_d   = s2_eop_q;
  end

  // Pipeline registers; reset flushes everything in flight without a partial eop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_sop_q       <= 1'b0;
      s1_eop_q       <= 1'b0;
      s1_data_q      <= '0;
      s2_valid_q     <= 1'b0;
      s2_sop_q       <= 1'b0;
      s2_eop_q       <= 1'b0;
      s2_prod_q      <= '0;
      source_valid_q <= 1'b0;
      source_sop_q   <= 1'b0;
      source_eop_q   <= 1'b0;
      source_data_q  <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sop_q       <= s1_sop_d;
      s1_eop_q       <= s1_eop_d;
      s1_data_q      <= s1_data_d;
      s2_valid_q     <= s2_valid_d;
      s2_sop_q       <= s2_sop_d;
      s2_eop_q       <= s2_eop_d;
      s2_prod_q      <= s2_prod_d;
      source_valid_q <= source_valid_d;
      source_sop_q   <= source_sop_d;
      source_eop_q   <= source_eop_d;
      source_data_q  <= source_data_d;
    end
  end

  // Sticky flag and saturating count; an error event beats a simultaneous clear.
  always_comb begin
    status_error_d = status_error_q;
    err_count_d    = err_count_q;
    if (err_event) begin
      status_error_d = 1'b1;
      if (clear_error) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (clear_error) begin
      status_error_d = 1'b0;
      err_count_d    = 8'd0;
    end
  end

  // Error status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_error_q <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      status_error_q <= status_error_d;
      err_count_q    <= err_count_d;
    end
  end

  assign source_valid = source_valid_q;
  assign source_sop   = source_sop_q;
  assign source_eop   = source_eop_q;
  assign source_data  = source_data_q;
  assign status_error = status_error_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_window_multiplier.sv
// Self-checking bench for window_multiplier with a packet-level reference model.
module tb_window_multiplier;

   localparam int  WIDTH = 14;
   localparam int  LEN   = 16;
   localparam int  CW    = 16;
   localparam real PI    = 3.14159265358979323846;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sink_valid = 1'b0;
   logic sink_sop = 1'b0;
   logic sink_eop = 1'b0;
   logic signed [WIDTH-1:0] sink_data = '0;
   logic clear_error = 1'b0;
   logic source_valid, source_sop, source_eop;
   logic signed [WIDTH-1:0] source_data;
   logic status_error;
   logic [7:0] err_count;

   int testsRun = 0;
   int testsFailed = 0;
   int cycCount = 0;

   typedef struct {bit v; bit sop; bit eop; longint data;} beat_t;
   typedef struct {bit sop; bit eop; longint data; int cyc;} logged_t;

   beat_t   expPipe[$];
   beat_t   curExp = '{0, 0, 0, 0};
   beat_t   nextExp;
   logged_t dutLog[$];

   bit mInPkt = 0;
   int mPos = 0;
   bit mErrFlag = 0;
   int mErrCnt = 0;
   bit mErrEv;

   window_multiplier #(
      .WIDTH      (WIDTH),
      .LENGTH     (LEN),
      .COEF_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sink_valid   (sink_valid),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sink_data    (sink_data),
      .source_valid (source_valid),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_data  (source_data),
      .clear_error  (clear_error),
      .status_error (status_error),
      .err_count    (err_count)
   );

   // Free-running clock and cycle stamp.
   always #5 clk = ~clk;

   always @(posedge clk) cycCount <= cycCount + 1;

   // Window value straight from the cosine formula.
   function automatic longint coefOf(input int n);
      real v;
      longint r;
      v = 0.5 * (1.0 - $cos(2.0 * PI * real'(n) / real'(LEN))) * 65536.0;
      r = longint'(v);
      if (r > 65535) r = 65535;
      return r;
   endfunction

   // Expected windowed sample: round half up, then clamp to the signed output range.
   function automatic longint windowed(input longint d, input int n);
      longint q;
      q = (d * coefOf(n) + 32768) >>> 16;
      if (q > 8191) q = 8191;
      if (q < -8192) q = -8192;
      return q;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit v, input bit sop, input bit eop, input longint d, input bit clr);
      sink_valid  = v;
      sink_sop    = v && sop;
      sink_eop    = v && eop;
      sink_data   = d[WIDTH-1:0];
      clear_error = clr;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   // mode 0: constant value; mode 1: random with value at n=8; mode 2: all random.
   task automatic sendPacket(input int mode, input longint value, input bit gapped, input int badEopAt);
      for (int k = 0; k < LEN; k++) begin
         longint d;
         d = longint'($urandom_range(16383)) - 8192;
         if (mode == 0 || (mode == 1 && k == 8)) d = value;
         applyStimulus(1, k == 0, (k == LEN - 1) || (k == badEopAt), d, 0);
         if (gapped) idleCycles(1);
      end
   endtask

   // Reference model: tracks packet position from sink beats and queues each expected output 3 clk ahead.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mInPkt = 0;
         mPos = 0;
         mErrFlag = 0;
         mErrCnt = 0;
         expPipe.delete();
         expPipe.push_back('{0, 0, 0, 0});
         expPipe.push_back('{0, 0, 0, 0});
         curExp = '{0, 0, 0, 0};
      end else begin
         nextExp = '{0, 0, 0, 0};
         mErrEv = 0;
         if (sink_valid) begin
            if (!mInPkt && !sink_sop) begin
               mErrEv = 1;
            end else begin
               if (sink_sop) begin
                  if (mInPkt) mErrEv = 1;
                  mPos = 0;
               end
               nextExp.v    = 1;
               nextExp.sop  = sink_sop;
               nextExp.eop  = (mPos == LEN - 1);
               nextExp.data = windowed(longint'(sink_data), mPos);
               if (sink_eop != nextExp.eop) mErrEv = 1;
               if (nextExp.eop) begin
                  mInPkt = 0;
                  mPos = 0;
               end else begin
                  mInPkt = 1;
                  mPos++;
               end
            end
         end
         if (mErrEv) begin
            mErrFlag = 1;
            mErrCnt = clear_error ? 1 : ((mErrCnt < 255) ? mErrCnt + 1 : 255);
         end else if (clear_error) begin
            mErrFlag = 0;
            mErrCnt = 0;
         end
         expPipe.push_back(nextExp);
         curExp = expPipe.pop_front();
      end
   end

   // Every cycle: compare outputs against the model and log emitted beats.
   always @(negedge clk) begin
      checkOutput("source_valid", source_valid, curExp.v);
      checkOutput("source_sop", source_sop, curExp.sop);
      checkOutput("source_eop", source_eop, curExp.eop);
      if (curExp.v) checkOutput("source_data", source_data, curExp.data);
      checkOutput("status_error", status_error, mErrFlag);
      checkOutput("err_count", err_count, mErrCnt);
      if (source_valid) dutLog.push_back('{source_sop, source_eop, longint'(source_data), cycCount});
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      int inCyc;
      int sopCnt;
      int eopCnt;
      int nonZero;

      #1;
      checkOutput("reset_valid", source_valid, 0);
      checkOutput("reset_err_count", err_count, 0);
      checkOutput("pin_w0", windowed(1000, 0), 0);
      checkOutput("pin_w4", windowed(1000, 4), 500);
      checkOutput("pin_w8", windowed(1000, 8), 1000);
      checkOutput("pin_w12", windowed(1000, 12), 500);
      checkOutput("pin_neg_extreme", windowed(-8192, 8), -8192);
      checkOutput("pin_pos_extreme", windowed(8191, 8), 8191);

      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(2);

      $display("[TB] scenario 1: constant packet");
      dutLog.delete();
      inCyc = cycCount;
      sendPacket(0, 1000, 0, -1);
      idleCycles(4);
      checkOutput("s1_count", dutLog.size(), LEN);
      if (dutLog.size() == LEN) begin
         checkOutput("s1_out0", dutLog[0].data, 0);
         checkOutput("s1_out4", dutLog[4].data, 500);
         checkOutput("s1_out8", dutLog[8].data, 1000);
         checkOutput("s1_out12", dutLog[12].data, 500);
         checkOutput("s1_sop0", dutLog[0].sop, 1);
         checkOutput("s1_eop15", dutLog[15].eop, 1);
         checkOutput("s1_latency", dutLog[0].cyc - inCyc, 3);
      end

      $display("[TB] scenario 2: extremes");
      dutLog.delete();
      sendPacket(1, -8192, 0, -1);
      idleCycles(4);
      if (dutLog.size() == LEN) checkOutput("s2_neg", dutLog[8].data, -8192);
      else checkOutput("s2_neg_count", dutLog.size(), LEN);
      dutLog.delete();
      sendPacket(1, 8191, 0, -1);
      idleCycles(4);
      if (dutLog.size() == LEN) checkOutput("s2_pos", dutLog[8].data, 8191);
      else checkOutput("s2_pos_count", dutLog.size(), LEN);
      dutLog.delete();
      sendPacket(0, 0, 0, -1);
      idleCycles(4);
      nonZero = 0;
      foreach (dutLog[i]) if (dutLog[i].data != 0) nonZero++;
      checkOutput("s2_zero_nonzero", nonZero, 0);

      $display("[TB] scenario 3: gapped input");
      dutLog.delete();
      sendPacket(0, 1000, 1, -1);
      idleCycles(4);
      checkOutput("s3_count", dutLog.size(), LEN);
      if (dutLog.size() == LEN) begin
         checkOutput("s3_out4", dutLog[4].data, 500);
         checkOutput("s3_out8", dutLog[8].data, 1000);
      end
      checkOutput("s3_err_count", err_count, 0);

      $display("[TB] scenario 4: framing errors");
      applyStimulus(0, 0, 0, 0, 1);
      dutLog.delete();
      applyStimulus(1, 0, 0, 77, 0);
      applyStimulus(1, 0, 0, 77, 0);
      idleCycles(4);
      checkOutput("s4a_outputs", dutLog.size(), 0);
      checkOutput("s4a_err_count", err_count, 2);
      dutLog.delete();
      for (int k = 0; k < 5; k++) applyStimulus(1, k == 0, 0, 100, 0);
      sendPacket(0, 100, 0, -1);
      idleCycles(4);
      sopCnt = 0;
      eopCnt = 0;
      foreach (dutLog[i]) begin
         if (dutLog[i].sop) sopCnt++;
         if (dutLog[i].eop) eopCnt++;
      end
      checkOutput("s4b_count", dutLog.size(), 21);
      checkOutput("s4b_sops", sopCnt, 2);
      checkOutput("s4b_eops", eopCnt, 1);
      checkOutput("s4b_err_count", err_count, 3);
      dutLog.delete();
      sendPacket(0, 200, 0, 9);
      idleCycles(4);
      checkOutput("s4c_err_count", err_count, 4);
      if (dutLog.size() == LEN) begin
         checkOutput("s4c_eop9", dutLog[9].eop, 0);
         checkOutput("s4c_eop15", dutLog[15].eop, 1);
      end else checkOutput("s4c_count", dutLog.size(), LEN);

      $display("[TB] scenario 5: error control");
      for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 5, 0);
      checkOutput("s5_saturated", err_count, 255);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("s5_clear_count", err_count, 0);
      checkOutput("s5_clear_flag", status_error, 0);
      applyStimulus(1, 0, 0, 5, 1);
      checkOutput("s5_race_count", err_count, 1);
      checkOutput("s5_race_flag", status_error, 1);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] scenario 6: reset mid-packet");
      for (int k = 0; k < 7; k++) applyStimulus(1, k == 0, 0, 1000, 0);
      sink_valid = 1'b0;
      sink_sop = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checkOutput("s6_valid", source_valid, 0);
      checkOutput("s6_sop", source_sop, 0);
      checkOutput("s6_eop", source_eop, 0);
      checkOutput("s6_data", source_data, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      dutLog.delete();
      applyStimulus(1, 0, 0, 300, 0);
      applyStimulus(1, 0, 0, 300, 0);
      checkOutput("s6_orphans", err_count, 2);
      sendPacket(0, 1000, 0, -1);
      idleCycles(4);
      checkOutput("s6_count", dutLog.size(), LEN);
      if (dutLog.size() == LEN) checkOutput("s6_out8", dutLog[8].data, 1000);

      $display("[TB] random traffic");
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < int'($urandom_range(2)); i++) applyStimulus(1, 0, 0, 11, 0);
         for (int k = 0; k < LEN; k++) begin
            bit sopX;
            bit eopX;
            sopX = (k == 0) || ($urandom_range(24) == 0);
            eopX = (k == LEN - 1) ^ ($urandom_range(24) == 0);
            applyStimulus(1, sopX, eopX, longint'($urandom_range(16383)) - 8192,
                          $urandom_range(30) == 0);
            while ($urandom_range(3) == 0) applyStimulus(0, 0, 0, 0, 0);
         end
      end
      idleCycles(5);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
